elastic_pipe_chain: RTL and testbench

//  Parametrised chain of STAGES enable-gated pipeline registers with a per-stage valid bit.

---
 rtl/elastic_pipe_chain_if.sv | 12 +
 rtl/elastic_pipe_chain.sv | 97 +++++++++
 tb/tb_elastic_pipe_chain.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_chain_if.sv
// Valid/ready handshake bundle carrying a WIDTH-bit payload between datapath blocks.
// The producer drives valid/data and the consumer drives ready.
interface elastic_pipe_chain_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_pipe_chain.sv
// Chain of STAGES valid-tagged pipeline registers with combinational ready back-propagation.
// Optional registered occupancy counter when PIPE_OCC_CNT_EN is defined.
module elastic_pipe_chain #(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_flush,
    elastic_pipe_chain_if.slave  i_in,
    elastic_pipe_chain_if.master o_out
`ifdef PIPE_OCC_CNT_EN
    ,
    output logic [OCC_W-1:0]     o_occupancy
`endif
);

    if (STAGES < 1) begin : g_bad_stages
        $error("elastic_pipe_chain: STAGES must be at least 1");
    end

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];

    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_up_valid;
    logic [WIDTH-1:0]  w_up_data [STAGES];

    // A stage can take new contents when it is empty or its own contents move on.
    assign w_rdy[STAGES] = o_out.ready;
    for (genvar i = 0; i < STAGES; i++) begin : g_rdy
        assign w_rdy[i] = ~r_valid[i] | w_rdy[i+1];
    end

    assign w_up_valid[0] = i_in.valid;
    assign w_up_data[0]  = i_in.data;
    for (genvar i = 1; i < STAGES; i++) begin : g_up
        assign w_up_valid[i] = r_valid[i-1];
        assign w_up_data[i]  = r_data[i-1];
    end

    assign i_in.ready  = w_rdy[0];
    assign o_out.valid = r_valid[STAGES-1];
    assign o_out.data  = r_data[STAGES-1];

    // NOTE: state uses non-blocking assignments so every stage samples the pre-edge values of its neighbour.
    // NOTE: the data registers are deliberately reset so out_data shows RESET_VAL until the first item leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_up_valid[i];
                    // Bubbles and flushed items leave the payload untouched.
                    if (w_up_valid[i] && !i_flush) begin
                        r_data[i] <= w_up_data[i];
                    end
                end
            end
            if (i_flush) begin
                r_valid <= '0;
            end
        end
    end

`ifdef PIPE_OCC_CNT_EN
    logic [OCC_W-1:0] r_occ;
    logic             w_in_hs;
    logic             w_out_hs;

    assign w_in_hs  = i_in.valid & w_rdy[0];
    assign w_out_hs = r_valid[STAGES-1] & o_out.ready;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_occ <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_hs && w_out_hs) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign o_occupancy = r_occ;

    a_occ_matches_valids : assert property (
        @(posedge clk) disable iff (reset) r_occ == OCC_W'($countones(r_valid))
    );
`endif

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Scoreboard bench for elastic_pipe_chain (WIDTH=8, STAGES=3, RESET_VAL=8'hA5).
// Occupancy checks are compiled in only when PIPE_OCC_CNT_EN is defined.
module tb_elastic_pipe_chain;

    localparam int         WIDTH     = 8;
    localparam int         STAGES    = 3;
    localparam logic [7:0] RESET_VAL = 8'hA5;

    logic clk;
    logic reset;
    logic flush;

    elastic_pipe_chain_if #(.WIDTH(WIDTH)) u_in ();
    elastic_pipe_chain_if #(.WIDTH(WIDTH)) u_out ();

`ifdef PIPE_OCC_CNT_EN
    logic [1:0] occ;
`endif

    elastic_pipe_chain #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flush),
        .i_in       (u_in),
        .o_out      (u_out)
`ifdef PIPE_OCC_CNT_EN
        ,
        .o_occupancy(occ)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] sb [$];
    int         n_vec;
    int         n_err;

    // One clock cycle: handshakes are sampled at the falling edge, then the bench
    // returns just after the rising edge so new inputs can be driven.
    task automatic step();
        logic [7:0] exp_v;
        @(negedge clk);
        if (!reset && u_out.valid === 1'b1 && u_out.ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_output got %h required no output", u_out.data);
            end else begin
                exp_v = sb.pop_front();
                if (u_out.data !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_out_data got %h required %h", u_out.data, exp_v);
                end
            end
        end
        if (reset || flush) begin
            sb.delete();
        end else if (u_in.valid === 1'b1 && u_in.ready === 1'b1) begin
            sb.push_back(u_in.data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if (u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready_during got %b required 1", u_in.ready);
        end
        n_vec++;
        if (u_out.valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got %b required 0", u_out.valid);
        end
        n_vec++;
        if (u_out.data !== RESET_VAL) begin
            n_err++; $display("FAIL reset_out_data got %h required %h", u_out.data, RESET_VAL);
        end
`ifdef PIPE_OCC_CNT_EN
        n_vec++;
        if (occ !== 2'd0) begin
            n_err++; $display("FAIL reset_occupancy got %0d required 0", occ);
        end
`endif
        reset = 1'b0;
        #1;
        n_vec++;
        if (u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready_after got %b required 1", u_in.ready);
        end
    endtask

    task automatic test_stream();
        logic exp_valid;
        u_out.ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            u_in.valid = (k < 8);
            u_in.data  = 8'(k + 1);
            #1;
            exp_valid = (k >= 3 && k < 11);
            n_vec++;
            if (u_out.valid !== exp_valid) begin
                n_err++; $display("FAIL stream_out_valid cycle %0d got %b required %b", k, u_out.valid, exp_valid);
            end
            step();
        end
        u_in.valid = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL stream_drain got %0d left required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        u_out.ready = 1'b0;
        u_in.valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u_in.data = 8'(8'h10 + k);
            #1;
            n_vec++;
            if (u_in.ready !== 1'b1) begin
                n_err++; $display("FAIL bp_accept item %0d got %b required 1", k, u_in.ready);
            end
            step();
        end
        u_in.data = 8'h13;
        #1;
        n_vec++;
        if (u_in.ready !== 1'b0) begin
            n_err++; $display("FAIL bp_full_in_ready got %b required 0", u_in.ready);
        end
        n_vec++;
        if (u_out.valid !== 1'b1 || u_out.data !== 8'h10) begin
            n_err++; $display("FAIL bp_head got v=%b d=%h required v=1 d=10", u_out.valid, u_out.data);
        end
`ifdef PIPE_OCC_CNT_EN
        n_vec++;
        if (occ !== 2'd3) begin
            n_err++; $display("FAIL bp_occupancy got %0d required 3", occ);
        end
`endif
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (u_out.data !== 8'h10 || u_in.ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold got d=%h rdy=%b required d=10 rdy=0", u_out.data, u_in.ready);
            end
        end
        u_out.ready = 1'b1;
        #1;
        n_vec++;
        if (u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release_in_ready got %b required 1", u_in.ready);
        end
        step();
        u_in.valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL bp_drain got %0d left required 0", sb.size());
        end
    endtask

    task automatic test_full_throughput();
        u_out.ready = 1'b0;
        u_in.valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u_in.data = 8'(8'h20 + k);
            step();
        end
        u_in.data   = 8'h23;
        u_out.ready = 1'b1;
        #1;
        n_vec++;
        if (u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL full_tp_in_ready got %b required 1", u_in.ready);
        end
        step();
        u_in.valid  = 1'b0;
        u_out.ready = 1'b0;
        #1;
        n_vec++;
        if (u_out.valid !== 1'b1 || u_out.data !== 8'h21 || u_in.ready !== 1'b0) begin
            n_err++; $display("FAIL full_tp_state got v=%b d=%h rdy=%b required v=1 d=21 rdy=0",
                              u_out.valid, u_out.data, u_in.ready);
        end
`ifdef PIPE_OCC_CNT_EN
        n_vec++;
        if (occ !== 2'd3) begin
            n_err++; $display("FAIL full_tp_occupancy got %0d required 3", occ);
        end
`endif
        u_out.ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL full_tp_drain got %0d left required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        u_out.ready = 1'b0;
        u_in.valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u_in.data = 8'(8'h30 + k);
            step();
        end
        flush       = 1'b1;
        u_in.data   = 8'hFF;
        u_out.ready = 1'b1;
        #1;
        n_vec++;
        if (u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL flush_in_ready got %b required 1", u_in.ready);
        end
        step();
        flush      = 1'b0;
        u_in.valid = 1'b0;
        #1;
        n_vec++;
        if (u_out.valid !== 1'b0) begin
            n_err++; $display("FAIL flush_out_valid got %b required 0", u_out.valid);
        end
        n_vec++;
        if (u_out.data !== 8'h30) begin
            n_err++; $display("FAIL flush_data_kept got %h required 30", u_out.data);
        end
`ifdef PIPE_OCC_CNT_EN
        n_vec++;
        if (occ !== 2'd0) begin
            n_err++; $display("FAIL flush_occupancy got %0d required 0", occ);
        end
`endif
        for (int k = 0; k < 5; k++) begin
            step();
            n_vec++;
            if (u_out.valid !== 1'b0) begin
                n_err++; $display("FAIL flush_no_ghost cycle %0d got %b required 0", k, u_out.valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        u_out.ready = 1'b0;
        u_in.valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            u_in.data = 8'(8'h40 + k);
            step();
        end
        u_in.valid = 1'b0;
        reset      = 1'b1;
        flush      = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        n_vec++;
        if (u_out.valid !== 1'b0 || u_out.data !== RESET_VAL || u_in.ready !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_state got v=%b d=%h rdy=%b required v=0 d=a5 rdy=1",
                              u_out.valid, u_out.data, u_in.ready);
        end
`ifdef PIPE_OCC_CNT_EN
        n_vec++;
        if (occ !== 2'd0) begin
            n_err++; $display("FAIL reset_mid_occupancy got %0d required 0", occ);
        end
`endif
        u_out.ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_vec++;
        if (u_out.valid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_no_survivor got %b required 0", u_out.valid);
        end
    endtask

    task automatic test_random();
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 10000; c++) begin
            u_in.valid  = ($urandom_range(0, 3) != 0);
            u_in.data   = 8'($urandom);
            u_out.ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                n_vec++;
                if (u_out.valid !== 1'b1 || u_out.data !== prev_data) begin
                    n_err++; $display("FAIL rand_hold cycle %0d got v=%b d=%h required v=1 d=%h",
                                      c, u_out.valid, u_out.data, prev_data);
                end
            end
            prev_stall = (u_out.valid === 1'b1) && (u_out.ready !== 1'b1);
            prev_data  = u_out.data;
            step();
`ifdef PIPE_OCC_CNT_EN
            n_vec++;
            if (occ !== 2'(sb.size())) begin
                n_err++; $display("FAIL rand_occupancy cycle %0d got %0d required %0d", c, occ, sb.size());
            end
`endif
        end
        u_in.valid  = 1'b0;
        u_out.ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL rand_drain got %0d left required 0", sb.size());
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        u_in.valid  = 1'b0;
        u_in.data   = '0;
        u_out.ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_throughput();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
